// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the register file write port, merging single-cycle ALU
//   results (priority, never stalled) with valid/ready load returns that are queued
//   while the ALU holds the port. Write outputs are registered: one cycle latency.
// Ports: C/rst clock and sync active-high reset; alu_* ALU result; ld_* load return
//   with ld_ready backpressure (low when queue full or in reset); Din/we/Rw register
//   file write port; Ra/Rb -> fwd_* forwarding of pending results; q_count occupancy.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                   C,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  input  logic                   ld_valid,
  input  logic [4:0]             ld_rd,
  input  logic [31:0]            ld_data,
  output logic                   ld_ready,
  output logic [31:0]            Din,
  output logic                   we,
  output logic [4:0]             Rw,
  input  logic [4:0]             Ra,
  input  logic [4:0]             Rb,
  output logic                   fwd_a_hit,
  output logic [31:0]            fwd_a_data,
  output logic                   fwd_b_hit,
  output logic [31:0]            fwd_b_data,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [DEPTH-1:0] q_vld;
  logic [4:0]       q_rd  [DEPTH];
  logic [31:0]      q_dat [DEPTH];

  logic q_empty;
  logic accept;
  logic sel_alu;
  logic pop;
  logic cut;
  logic enq;

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot early.
  assign ld_ready = !rst && (q_count < (AW+1)'(DEPTH));
  assign q_empty  = (q_count == '0);
  assign accept   = ld_valid && ld_ready;
  assign sel_alu  = alu_valid && (alu_rd != 5'd0);
  assign pop      = !sel_alu && !q_empty;
  // A load only bypasses the queue when nothing older is waiting.
  assign cut      = !sel_alu && q_empty && accept && (ld_rd != 5'd0);
  assign enq      = accept && (ld_rd != 5'd0) && !cut;

  always_ff @(posedge C) begin
    if (rst) begin
      we      <= 1'b0;
      Rw      <= 5'd0;
      Din     <= 32'd0;
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
      q_vld   <= '0;
    end else begin
      we <= 1'b0;
      if (sel_alu) begin
        we  <= 1'b1;
        Rw  <= alu_rd;
        Din <= alu_data;
        // Older queued loads to the same register would overwrite the younger ALU value.
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == alu_rd) q_vld[i] <= 1'b0;
        end
      end else if (pop) begin
        // A killed head still consumes this cycle, without a write.
        if (q_vld[head]) begin
          we  <= 1'b1;
          Rw  <= q_rd[head];
          Din <= q_dat[head];
        end
        q_vld[head] <= 1'b0;
        head        <= head + 1'b1;
      end else if (cut) begin
        we  <= 1'b1;
        Rw  <= ld_rd;
        Din <= ld_data;
      end
      // The tail slot is free whenever enq is set, so this never fights the kill above.
      if (enq) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({enq, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Payload storage needs no reset: q_vld qualifies every entry.
  always_ff @(posedge C) begin
    if (enq) begin
      q_rd[tail]  <= ld_rd;
      q_dat[tail] <= ld_data;
    end
  end

  // Walk the queue oldest to youngest so the last match is the youngest value;
  // the output register is older than anything still queued.
  function automatic logic [32:0] lookup(input logic [4:0] r);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    if (we && (Rw == r)) res = {1'b1, Din};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (q_vld[idx] && (q_rd[idx] == r)) res = {1'b1, q_dat[idx]};
    end
    if (r == 5'd0) res = '0;
    return res;
  endfunction

  assign {fwd_a_hit, fwd_a_data} = lookup(Ra);
  assign {fwd_b_hit, fwd_b_data} = lookup(Rb);

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side initiator for the 32x32 register file. It owns the file's write port (Din, we, Rw).
- It merges two result sources:
  - the single-cycle ALU path, which has priority and is never stalled;
  - the variable-latency load-return path, which has a valid/ready handshake.
- Load results are buffered in a small queue while the ALU holds the write port.
- A forwarding lookup is provided so decode sees results still pending in this block.

Parameters:
DEPTH, 4, load-result queue entries (power of two, >= 2)

Ports:
C  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load result offered
ld_rd  input  5  load destination register
ld_data  input  32  load data
ld_ready  output  1  load result accepted when ld_valid & ld_ready
Din  output  32  register file write data
we  output  1  register file write enable
Rw  output  5  register file write address
Ra  input  5  forwarding query A (same index as file read port A)
Rb  input  5  forwarding query B
fwd_a_hit  output  1  pending value exists for Ra
fwd_a_data  output  32  that value
fwd_b_hit  output  1  pending value exists for Rb
fwd_b_data  output  32  that value
q_count  output  clog2(DEPTH)+1  occupied queue entries

Behaviour:
- Clock C, reset rst: one clock; reset is synchronous and active-high. All state changes on the rising edge of C.
- Reset values:
  - we=0, Rw=0, Din=0.
  - Queue empty, q_count=0, all entries invalid.
  - fwd_*_hit=0.
  - ld_ready=0 while rst=1.
- Mid-operation reset: queued loads and any pending write are discarded; no write is issued in the cycle after reset.
- Outputs Din/we/Rw are registered. A source selected in cycle N produces we=1 in cycle N+1; the register file commits at the end of N+1.
- Per-cycle selection for the output register:
  1. alu_valid & alu_rd!=0 → ALU result.
  2. Else, queue non-empty → queue head, which is popped.
  3. Else, accepted load with ld_rd!=0 → cut-through; not enqueued.
  4. Else → we=0.
- An accepted load not chosen by step 3 is enqueued at the tail. This applies when the ALU wins, or when the queue is non-empty.
- Destination x0:
  - ALU writes to x0 are ignored.
  - Loads to x0 are accepted (handshake completes) but dropped: not enqueued, no write.
- ld_ready = !rst & (q_count < DEPTH). A pop in the same cycle does not raise ready (no combinational full-bypass).
- Simultaneous enqueue and dequeue: q_count unchanged. Pointers wrap modulo DEPTH.
- WAW kill: when an ALU write to rd is selected, every valid queue entry with the same rd is invalidated in that cycle (the ALU result is younger in program order).
  - Invalid entries still occupy their slot.
  - An invalid entry reaching the head is popped with no write, and the next candidate may not use that cycle.
  - A load arriving in the same cycle with the same rd is younger and is NOT killed.
- Forwarding is combinational from state:
  - Candidates are valid queue entries and the output register (when we=1).
  - Youngest match wins: tail-most valid queue entry first, then the output register.
  - Query index 0 never hits.
  - Inputs alu_* and ld_* of the current cycle are not candidates.
- q_count counts slots, including killed entries.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle → next cycle we=1, Rw=5, Din=0x1234; fwd_a_hit=1 with Ra=5; following cycle we=0.
- Idle queue; ld_valid=1, ld_rd=7, ld_data=0xAA → cut-through: next cycle we=1, Rw=7, Din=0xAA; q_count stays 0.
- Hold alu_valid=1 (rd=1..) for 6 cycles while offering loads rd=10..13:
  - q_count reaches 4; ld_ready drops to 0 and the 5th load stalls.
  - After ALU idles, writes Rw=10,11,12,13 on consecutive cycles; ld_ready returns.
- Queue holds load rd=9 data=0x11; ALU writes rd=9 data=0x22 → entry killed; Rw=9 written only with 0x22; q_count still 1 until the killed entry pops without a write.
- Load to rd=0 → ld_ready handshake completes, no we pulse, q_count unchanged; ALU rd=0 → no we.
- rst asserted while queue holds 3 entries → next cycle q_count=0, we=0, ld_ready=0; no queued write appears after rst deasserts.
